// File: rtl/fft_pkg.sv
// Shared definitions for the serialising stage behind the radix-4 butterfly:
// component width, buffer geometry and occupancy state encoding.
package fft_pkg;

    localparam int BIT_DEF = 17;
    localparam int N_SLOT  = 2;
    localparam int N_PT    = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/fft_ser_slot.sv
// One buffer slot: four complex points captured together on load,
// read back one point at a time through a 2-bit select.
module fft_ser_slot
    import fft_pkg::*;
#(
    parameter int BIT = BIT_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  load,
    input  logic signed [BIT-1:0] ld_re [N_PT],
    input  logic signed [BIT-1:0] ld_im [N_PT],
    input  logic [1:0]            sel,
    output logic signed [BIT-1:0] rd_re,
    output logic signed [BIT-1:0] rd_im
);

    logic signed [BIT-1:0] re_q [N_PT];
    logic signed [BIT-1:0] im_q [N_PT];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < N_PT; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_PT; i++) begin
                re_q[i] <= ld_re[i];
                im_q[i] <= ld_im[i];
            end
        end
    end

    assign rd_re = re_q[sel];
    assign rd_im = im_q[sel];

endmodule

// File: rtl/fft_but_ser.sv
// Ping-pong buffer that turns one 4-point butterfly result per load into a
// valid/ready stream of single complex samples, tagged with index and last.
module fft_but_ser
    import fft_pkg::*;
#(
    parameter int BIT = BIT_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iLOAD,
    input  logic signed [BIT-1:0] iY0_RE,
    input  logic signed [BIT-1:0] iY0_IM,
    input  logic signed [BIT-1:0] iY1_RE,
    input  logic signed [BIT-1:0] iY1_IM,
    input  logic signed [BIT-1:0] iY2_RE,
    input  logic signed [BIT-1:0] iY2_IM,
    input  logic signed [BIT-1:0] iY3_RE,
    input  logic signed [BIT-1:0] iY3_IM,
    output logic                  oREADY,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic signed [BIT-1:0] oRE,
    output logic signed [BIT-1:0] oIM,
    output logic [1:0]            oIDX,
    output logic                  oLAST,
    output logic                  oOVF,
    output logic [1:0]            oSTATE
);

    // Handshake: a sample moves downstream on every rising edge where oVALID
    // and iREADY are both high; oVALID never depends on iREADY, and the
    // presented sample stays unchanged until it has moved.

    occ_e                  state_q, state_d;
    logic                  wp_q, rp_q;
    logic [1:0]            cnt_q;
    logic                  ovf_q;
    logic                  accept, xfer, last_xfer;
    logic signed [BIT-1:0] y_re [N_PT];
    logic signed [BIT-1:0] y_im [N_PT];
    logic signed [BIT-1:0] slot_re [N_SLOT];
    logic signed [BIT-1:0] slot_im [N_SLOT];

    assign y_re[0] = iY0_RE;
    assign y_re[1] = iY1_RE;
    assign y_re[2] = iY2_RE;
    assign y_re[3] = iY3_RE;
    assign y_im[0] = iY0_IM;
    assign y_im[1] = iY1_IM;
    assign y_im[2] = iY2_IM;
    assign y_im[3] = iY3_IM;

    assign oREADY    = (state_q != FULL);
    assign oVALID    = (state_q != EMPTY);
    assign accept    = iLOAD && oREADY;
    assign xfer      = oVALID && iREADY;
    assign last_xfer = xfer && (cnt_q == 2'd3);

    for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
        fft_ser_slot #(.BIT(BIT)) u_slot (
            .iCLK   (iCLK),
            .iRESET (iRESET),
            .load   (accept && (wp_q == 1'(g))),
            .ld_re  (y_re),
            .ld_im  (y_im),
            .sel    (cnt_q),
            .rd_re  (slot_re[g]),
            .rd_im  (slot_im[g])
        );
    end

    // A load that coincides with the final sample of a group keeps occupancy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = HALF;
            HALF: begin
                if (accept && !last_xfer)      state_d = FULL;
                else if (!accept && last_xfer) state_d = EMPTY;
            end
            FULL:    if (last_xfer) state_d = HALF;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= EMPTY;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            cnt_q   <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_q ^ accept;
            rp_q    <= rp_q ^ last_xfer;
            if (xfer)              cnt_q <= cnt_q + 2'd1;
            if (iLOAD && !oREADY)  ovf_q <= 1'b1;
        end
    end

    assign oRE    = slot_re[rp_q];
    assign oIM    = slot_im[rp_q];
    assign oIDX   = cnt_q;
    assign oLAST  = oVALID && (cnt_q == 2'd3);
    assign oOVF   = ovf_q;
    assign oSTATE = state_q;

endmodule

// File: tb/tb_fft_but_ser.sv
// Directed bench for fft_but_ser: a sample-queue model predicts the stream,
// occupancy and overflow flag every cycle; literal checks pin the model.
module tb_fft_but_ser;

    localparam int BIT = 17;
    localparam int W   = 2 * BIT + 2;

    logic                  iCLK, iRESET, iLOAD, iREADY;
    logic signed [BIT-1:0] iY0_RE, iY0_IM, iY1_RE, iY1_IM;
    logic signed [BIT-1:0] iY2_RE, iY2_IM, iY3_RE, iY3_IM;
    logic                  oREADY, oVALID, oLAST, oOVF;
    logic signed [BIT-1:0] oRE, oIM;
    logic [1:0]            oIDX, oSTATE;

    int total = 0;
    int bad   = 0;

    // expected samples, front = presented now: {re, im, idx}
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;

    fft_but_ser #(.BIT(BIT)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iLOAD  (iLOAD),
        .iY0_RE (iY0_RE),
        .iY0_IM (iY0_IM),
        .iY1_RE (iY1_RE),
        .iY1_IM (iY1_IM),
        .iY2_RE (iY2_RE),
        .iY2_IM (iY2_IM),
        .iY3_RE (iY3_RE),
        .iY3_IM (iY3_IM),
        .oREADY (oREADY),
        .oVALID (oVALID),
        .iREADY (iREADY),
        .oRE    (oRE),
        .oIM    (oIM),
        .oIDX   (oIDX),
        .oLAST  (oLAST),
        .oOVF   (oOVF),
        .oSTATE (oSTATE)
    );

    // clock / reset
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // drivers: inputs change 2 time units after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #2;
        end
    endtask

    task automatic load4(input int r0, input int i0, input int r1, input int i1,
                         input int r2, input int i2, input int r3, input int i3);
        iY0_RE = BIT'(r0); iY0_IM = BIT'(i0);
        iY1_RE = BIT'(r1); iY1_IM = BIT'(i1);
        iY2_RE = BIT'(r2); iY2_IM = BIT'(i2);
        iY3_RE = BIT'(r3); iY3_IM = BIT'(i3);
        iLOAD  = 1'b1;
        tick(1);
        iLOAD  = 1'b0;
    endtask

    // model: whole groups in, one sample out per accepted transfer
    always @(posedge iCLK) begin
        int groups;
        if (!iRESET) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            groups = (exp_q.size() + 3) / 4;
            if (exp_q.size() > 0 && iREADY) void'(exp_q.pop_front());
            if (iLOAD) begin
                if (groups < 2) begin
                    exp_q.push_back({iY0_RE, iY0_IM, 2'd0});
                    exp_q.push_back({iY1_RE, iY1_IM, 2'd1});
                    exp_q.push_back({iY2_RE, iY2_IM, 2'd2});
                    exp_q.push_back({iY3_RE, iY3_IM, 2'd3});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge iCLK) begin
        logic signed [BIT-1:0] e_re, e_im;
        logic [1:0]            e_idx;
        int                    groups;
        if (!iRESET) begin
            chk("rst_valid", oVALID, 0);
            chk("rst_ready", oREADY, 1);
            chk("rst_ovf",   oOVF,   0);
            chk("rst_re",    oRE,    0);
            chk("rst_im",    oIM,    0);
            chk("rst_idx",   oIDX,   0);
            chk("rst_last",  oLAST,  0);
        end else begin
            groups = (exp_q.size() + 3) / 4;
            chk("valid", oVALID, (exp_q.size() > 0) ? 1 : 0);
            chk("ready", oREADY, (groups < 2) ? 1 : 0);
            chk("state", oSTATE, groups);
            chk("ovf",   oOVF,   m_ovf);
            if (exp_q.size() > 0) begin
                {e_re, e_im, e_idx} = exp_q[0];
                chk("re",   oRE,   e_re);
                chk("im",   oIM,   e_im);
                chk("idx",  oIDX,  e_idx);
                chk("last", oLAST, (e_idx == 2'd3) ? 1 : 0);
            end else begin
                chk("last_idle", oLAST, 0);
            end
        end
    end

    initial begin
        iRESET = 1'b0; iLOAD = 1'b0; iREADY = 1'b0;
        iY0_RE = '0; iY0_IM = '0; iY1_RE = '0; iY1_IM = '0;
        iY2_RE = '0; iY2_IM = '0; iY3_RE = '0; iY3_IM = '0;
        tick(2);
        iRESET = 1'b1;
        tick(1);

        // single group, sink always ready
        iREADY = 1'b1;
        load4(1, -1, 2, -2, 3, -3, 4, -4);
        @(negedge iCLK);
        chk("t1_valid0", oVALID, 1);
        chk("t1_re0",  oRE,  1);
        chk("t1_im0",  oIM,  -1);
        chk("t1_idx0", oIDX, 0);
        chk("t1_last0", oLAST, 0);
        @(negedge iCLK);
        @(negedge iCLK);
        @(negedge iCLK);
        chk("t1_re3",   oRE,   4);
        chk("t1_im3",   oIM,   -4);
        chk("t1_idx3",  oIDX,  3);
        chk("t1_last3", oLAST, 1);
        @(negedge iCLK);
        chk("t1_drained", oVALID, 0);
        tick(1);

        // back-to-back groups four cycles apart
        load4(5, 6, 7, 8, 9, 10, 11, 12);
        tick(3);
        load4(-5, -6, -7, -8, -9, -10, -11, -12);
        tick(8);

        // backpressure, overflow, then drain
        iREADY = 1'b0;
        load4(10, -10, 11, -11, 12, -12, 13, -13);
        load4(20, -20, 21, -21, 22, -22, 23, -23);
        @(negedge iCLK);
        chk("t3_ready_full", oREADY, 0);
        load4(30, -30, 31, -31, 32, -32, 33, -33);
        @(negedge iCLK);
        chk("t3_ovf", oOVF, 1);
        chk("t3_hold_re", oRE, 10);
        tick(1);
        iREADY = 1'b1;
        @(negedge iCLK);
        chk("t3_first_re",  oRE,  10);
        chk("t3_first_im",  oIM,  -10);
        chk("t3_first_idx", oIDX, 0);
        tick(10);

        // load coinciding with the final transfer of a group
        load4(40, 41, 42, 43, 44, 45, 46, 47);
        tick(3);
        @(negedge iCLK);
        chk("t4_idx3", oIDX, 3);
        load4(50, 51, 52, 53, 54, 55, 56, 57);
        @(negedge iCLK);
        chk("t4_new_idx",   oIDX,   0);
        chk("t4_new_re",    oRE,    50);
        chk("t4_ready",     oREADY, 1);
        chk("t4_state_half", oSTATE, 1);
        tick(6);

        // extreme values
        load4(-65536, 65535, 65535, -65536, -1, 0, 0, -1);
        @(negedge iCLK);
        chk("t5_min_re", oRE, -65536);
        chk("t5_max_im", oIM, 65535);
        @(negedge iCLK);
        chk("t5_max_re", oRE, 65535);
        chk("t5_min_im", oIM, -65536);
        tick(5);

        // asynchronous reset in the middle of a group
        load4(7, 70, 8, 80, 9, 90, 6, 60);
        tick(2);
        #1;
        iRESET = 1'b0;
        #1;
        chk("t6_async_valid", oVALID, 0);
        chk("t6_async_ovf",   oOVF,   0);
        chk("t6_async_re",    oRE,    0);
        chk("t6_async_idx",   oIDX,   0);
        tick(2);
        iRESET = 1'b1;
        tick(1);
        load4(60, 61, 62, 63, 64, 65, 66, 67);
        @(negedge iCLK);
        chk("t6_restart_valid", oVALID, 1);
        chk("t6_restart_idx",   oIDX,   0);
        chk("t6_restart_re",    oRE,    60);
        tick(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_but_ser.md
FFT_BUT_SER -- requirements
Module: fft_but_ser

Interface
REQ-001 Parameter: BIT, default 17, width of each signed real/imaginary component, matching the butterfly output width.
REQ-002 iCLK  input  1  single clock; all state updates on rising edge.
REQ-003 iRESET  input  1  asynchronous, active-low reset.
REQ-004 iLOAD  input  1  one-cycle pulse: the four complex points on iY0..iY3 are valid this cycle.
REQ-005 iY0_RE, iY0_IM, iY1_RE, iY1_IM, iY2_RE, iY2_IM, iY3_RE, iY3_IM  input  BIT each  signed butterfly results, sampled on iLOAD.
REQ-006 oREADY  output  1  block can accept an iLOAD this cycle.
REQ-007 oVALID  output  1  oRE/oIM/oIDX hold a valid sample.
REQ-008 iREADY  input  1  downstream accepts the sample; a transfer occurs when oVALID and iREADY are both high.
REQ-009 oRE, oIM  output  BIT each  signed serialized sample.
REQ-010 oIDX  output  2  index (0..3) of the current sample within its group.
REQ-011 oLAST  output  1  high with the oIDX=3 sample.
REQ-012 oOVF  output  1  sticky flag: iLOAD arrived while oREADY was low.

Function
REQ-013 Storage: two 4-point slots (ping-pong); occupancy counter OCC in {0,1,2}; write pointer WP and read pointer RP (1 bit each); sample counter CNT (2 bits).
REQ-014 States: EMPTY (OCC=0), HALF (OCC=1), FULL (OCC=2); oREADY is low only in FULL (combinational from registered OCC).
REQ-015 iLOAD with oREADY high: capture all 8 inputs into slot WP, toggle WP, OCC+1.
REQ-016 iLOAD with oREADY low: data discarded, no state change except oOVF set to 1 (until reset).
REQ-017 oVALID is high whenever OCC>0; oRE/oIM are the point CNT of slot RP, oIDX=CNT, all driven from registers/muxed registered storage.
REQ-018 On a transfer: CNT+1; when CNT=3, CNT wraps to 0, RP toggles and OCC-1.
REQ-019 Simultaneous accepted iLOAD and final (CNT=3) transfer: OCC unchanged, both pointers toggle.
REQ-020 Latency: iLOAD accepted in cycle N with OCC=0 gives oVALID=1, oIDX=0 in cycle N+1.
REQ-021 With iREADY held high, a group drains in exactly 4 cycles with no bubble between back-to-back groups.
REQ-022 iREADY low: oRE, oIM, oIDX, oLAST held stable while oVALID high.
REQ-023 Data passes bit-exact; no rounding, scaling or sign change.

Reset
REQ-024 iRESET low asynchronously clears OCC, WP, RP, CNT and oOVF; oVALID=0, oLAST=0, oIDX=0, oRE=0, oIM=0, oREADY=1.
REQ-025 Reset mid-group discards all buffered points; first load after release starts at oIDX=0.
REQ-026 Slot storage contents are cleared to 0 on reset.

Structure
REQ-027 Shared fft package holds BIT default, slot count (2), points per group (4) and state encodings EMPTY/HALF/FULL.
REQ-028 One sub-module, fft_ser_slot: 4-point complex register bank with load enable and 2-bit read select, instantiated twice.

Verification
REQ-029 Single group: iLOAD Y0=(1,-1), Y1=(2,-2), Y2=(3,-3), Y3=(4,-4), iREADY=1 -> cycles N+1..N+4 output (1,-1)..(4,-4), oIDX 0..3, oLAST only at (4,-4).
REQ-030 Back-to-back: loads at N and N+4, iREADY=1 -> 8 contiguous valid samples, oREADY never low.
REQ-031 Backpressure: two loads, iREADY=0 -> OCC=2, oREADY=0; third iLOAD -> oOVF=1, first drained group data unchanged after iREADY=1.
REQ-032 Simultaneous: FULL, iLOAD ignored; HALF with oIDX=3 transfer plus iLOAD -> OCC stays 1, next sample is new group point 0.
REQ-033 Extremes: points -65536 and 65535 (BIT=17) pass bit-exact.
REQ-034 Reset at oIDX=2 -> oVALID=0 immediately (asynchronous), oOVF=0, next load restarts at oIDX=0.
